mem_wb: RTL and testbench

MEM_WB -- requirements
Module: mem_wb

---
 rtl/mips_pkg.sv | 19 +
 rtl/load_align.sv | 46 ++++
 rtl/mem_wb.sv | 138 +++++++++++++
 tb/tb_mem_wb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared datapath widths and load-type encodings for the MIPS pipeline.
package mips_pkg;

   localparam int RegBusWidth      = 32;
   localparam int RegAddrWidth     = 5;
   localparam int LoadTypeWidth    = 3;
   localparam int RetireCountWidth = 32;

   // Codes 6 and 7 are unused and behave like LOAD_NONE.
   typedef enum logic [LoadTypeWidth-1:0] {
      LOAD_NONE = 3'd0,
      LOAD_LB   = 3'd1,
      LOAD_LBU  = 3'd2,
      LOAD_LH   = 3'd3,
      LOAD_LHU  = 3'd4,
      LOAD_LW   = 3'd5
   } load_type_e;

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction (big-endian byte lanes) and misalignment detection.
module load_align
   import mips_pkg::*;
(
   input  logic [RegBusWidth-1:0]   word_i,
   input  logic [1:0]               addr_low_i,
   input  logic [LoadTypeWidth-1:0] load_type_i,
   output logic [RegBusWidth-1:0]   data_o,
   output logic                     misalign_o
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   // Offset 0 is the most significant byte.
   always_comb begin
      byteSel = word_i[31:24];
      case (addr_low_i)
         2'd0:    byteSel = word_i[31:24];
         2'd1:    byteSel = word_i[23:16];
         2'd2:    byteSel = word_i[15:8];
         default: byteSel = word_i[7:0];
      endcase
      halfSel = addr_low_i[1] ? word_i[15:0] : word_i[31:16];
   end

   always_comb begin
      data_o     = word_i;
      misalign_o = 1'b0;
      case (load_type_i)
         LOAD_LB:  data_o = {{(RegBusWidth-8){byteSel[7]}}, byteSel};
         LOAD_LBU: data_o = {{(RegBusWidth-8){1'b0}}, byteSel};
         LOAD_LH: begin
            data_o     = {{(RegBusWidth-16){halfSel[15]}}, halfSel};
            misalign_o = addr_low_i[0];
         end
         LOAD_LHU: begin
            data_o     = {{(RegBusWidth-16){1'b0}}, halfSel};
            misalign_o = addr_low_i[0];
         end
         LOAD_LW:  misalign_o = (addr_low_i != 2'd0);
         default:  data_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with load alignment and retire counter.
// Define WB_BYPASS_EN to add the byp_* forwarding copy of the previous WB entry.
module mem_wb
   import mips_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_valid,
   input  logic [RegBusWidth-1:0]      mem_write_data,
   input  logic [RegAddrWidth-1:0]     mem_write_reg_addr,
   input  logic                        mem_reg_write_en,
   input  logic [LoadTypeWidth-1:0]    mem_load_type,
   input  logic [1:0]                  mem_addr_low,
   input  logic                        stall,
   input  logic                        flush,
   output logic [RegBusWidth-1:0]      write_data,
   output logic [RegAddrWidth-1:0]     write_reg_addr,
   output logic                        reg_write_en,
   output logic                        wb_valid,
   output logic                        load_misalign,
   output logic [RetireCountWidth-1:0] retire_count
`ifdef WB_BYPASS_EN
   ,
   output logic                        byp_en,
   output logic [RegAddrWidth-1:0]     byp_addr,
   output logic [RegBusWidth-1:0]      byp_data
`endif
);

   logic [RegBusWidth-1:0]      alignedData;
   logic                        misaligned;

   logic                        wbValid_q, wbValid_d;
   logic                        regWriteEn_q, regWriteEn_d;
   logic                        loadMisalign_q, loadMisalign_d;
   logic [RegBusWidth-1:0]      writeData_q, writeData_d;
   logic [RegAddrWidth-1:0]     writeRegAddr_q, writeRegAddr_d;
   logic [RetireCountWidth-1:0] retireCount_q, retireCount_d;

   load_align u_load_align (
      .word_i      (mem_write_data),
      .addr_low_i  (mem_addr_low),
      .load_type_i (mem_load_type),
      .data_o      (alignedData),
      .misalign_o  (misaligned)
   );

   // Flush wins over stall; the retire counter is never touched by either.
   always_comb begin
      wbValid_d      = wbValid_q;
      regWriteEn_d   = regWriteEn_q;
      loadMisalign_d = loadMisalign_q;
      writeData_d    = writeData_q;
      writeRegAddr_d = writeRegAddr_q;
      retireCount_d  = retireCount_q;
      if (flush) begin
         wbValid_d      = 1'b0;
         regWriteEn_d   = 1'b0;
         loadMisalign_d = 1'b0;
         writeData_d    = '0;
         writeRegAddr_d = '0;
      end else if (!stall) begin
         wbValid_d      = mem_valid;
         writeRegAddr_d = mem_write_reg_addr;
         writeData_d    = alignedData;
         loadMisalign_d = misaligned;
         regWriteEn_d   = mem_valid & mem_reg_write_en &
                          (mem_write_reg_addr != '0) & ~misaligned;
         if (mem_valid && !misaligned) begin
            retireCount_d = retireCount_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbValid_q      <= 1'b0;
         regWriteEn_q   <= 1'b0;
         loadMisalign_q <= 1'b0;
         writeData_q    <= '0;
         writeRegAddr_q <= '0;
         retireCount_q  <= '0;
      end else begin
         wbValid_q      <= wbValid_d;
         regWriteEn_q   <= regWriteEn_d;
         loadMisalign_q <= loadMisalign_d;
         writeData_q    <= writeData_d;
         writeRegAddr_q <= writeRegAddr_d;
         retireCount_q  <= retireCount_d;
      end
   end

   assign write_data     = writeData_q;
   assign write_reg_addr = writeRegAddr_q;
   assign reg_write_en   = regWriteEn_q;
   assign wb_valid       = wbValid_q;
   assign load_misalign  = loadMisalign_q;
   assign retire_count   = retireCount_q;

`ifdef WB_BYPASS_EN
   logic                    bypEn_q, bypEn_d;
   logic [RegAddrWidth-1:0] bypAddr_q, bypAddr_d;
   logic [RegBusWidth-1:0]  bypData_q, bypData_d;

   // On capture the outgoing WB write port slides into the bypass copy.
   always_comb begin
      bypEn_d   = bypEn_q;
      bypAddr_d = bypAddr_q;
      bypData_d = bypData_q;
      if (flush) begin
         bypEn_d   = 1'b0;
         bypAddr_d = '0;
         bypData_d = '0;
      end else if (!stall) begin
         bypEn_d   = regWriteEn_q;
         bypAddr_d = writeRegAddr_q;
         bypData_d = writeData_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bypEn_q   <= 1'b0;
         bypAddr_q <= '0;
         bypData_q <= '0;
      end else begin
         bypEn_q   <= bypEn_d;
         bypAddr_q <= bypAddr_d;
         bypData_q <= bypData_d;
      end
   end

   assign byp_en   = bypEn_q;
   assign byp_addr = bypAddr_q;
   assign byp_data = bypData_q;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb: driver pushes model predictions, monitor pops and compares each cycle.
module tb_mem_wb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_write_data = '0;
   logic [4:0]  mem_write_reg_addr = '0;
   logic        mem_reg_write_en = 1'b0;
   logic [2:0]  mem_load_type = '0;
   logic [1:0]  mem_addr_low = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] write_data;
   logic [4:0]  write_reg_addr;
   logic        reg_write_en;
   logic        wb_valid;
   logic        load_misalign;
   logic [31:0] retire_count;
`ifdef WB_BYPASS_EN
   logic        byp_en;
   logic [4:0]  byp_addr;
   logic [31:0] byp_data;
`endif

   mem_wb dut (
      .clk                (clk),
      .rst                (rst),
      .mem_valid          (mem_valid),
      .mem_write_data     (mem_write_data),
      .mem_write_reg_addr (mem_write_reg_addr),
      .mem_reg_write_en   (mem_reg_write_en),
      .mem_load_type      (mem_load_type),
      .mem_addr_low       (mem_addr_low),
      .stall              (stall),
      .flush              (flush),
      .write_data         (write_data),
      .write_reg_addr     (write_reg_addr),
      .reg_write_en       (reg_write_en),
      .wb_valid           (wb_valid),
      .load_misalign      (load_misalign),
      .retire_count       (retire_count)
`ifdef WB_BYPASS_EN
      ,
      .byp_en             (byp_en),
      .byp_addr           (byp_addr),
      .byp_data           (byp_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        rwe;
      logic        mis;
      logic [31:0] data;
      logic [4:0]  addr;
      logic [31:0] cnt;
      logic        bypEn;
      logic [4:0]  bypAddr;
      logic [31:0] bypData;
   } exp_t;

   exp_t model;
   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] refData(input logic [31:0] word, input int lt, input int off);
      logic [31:0] b;
      logic [31:0] h;
      b = (word >> (8 * (3 - off))) & 32'hFF;
      h = (word >> (16 * (1 - off / 2))) & 32'hFFFF;
      case (lt)
         1:       return (b >= 32'h80) ? b - 32'h100 : b;
         2:       return b;
         3:       return (h >= 32'h8000) ? h - 32'h10000 : h;
         4:       return h;
         default: return word;
      endcase
   endfunction

   function automatic logic refMis(input int lt, input int off);
      return ((lt == 3 || lt == 4) && (off % 2 == 1)) || (lt == 5 && off != 0);
   endfunction

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp("wb_valid", 32'(wb_valid), 32'(e.valid));
      cmp("reg_write_en", 32'(reg_write_en), 32'(e.rwe));
      cmp("load_misalign", 32'(load_misalign), 32'(e.mis));
      cmp("write_data", write_data, e.data);
      cmp("write_reg_addr", 32'(write_reg_addr), 32'(e.addr));
      cmp("retire_count", retire_count, e.cnt);
`ifdef WB_BYPASS_EN
      cmp("byp_en", 32'(byp_en), 32'(e.bypEn));
      cmp("byp_addr", 32'(byp_addr), 32'(e.bypAddr));
      cmp("byp_data", byp_data, e.bypData);
`endif
   endtask

   task automatic checkAllZero(input string tag);
      exp_t z;
      z = '{default: '0};
      $display("[TB] checking cleared outputs (%s)", tag);
      checkOutput(z);
   endtask

   // Drive one MEM entry on the falling edge and predict the WB state after the next rising edge.
   task automatic applyStimulus(input logic v, input logic [31:0] word, input logic [4:0] ra,
                                input logic rwe, input int lt, input int off,
                                input logic st, input logic fl);
      exp_t prev;
      logic mis;
      @(negedge clk);
      mem_valid          = v;
      mem_write_data     = word;
      mem_write_reg_addr = ra;
      mem_reg_write_en   = rwe;
      mem_load_type      = 3'(lt);
      mem_addr_low       = 2'(off);
      stall              = st;
      flush              = fl;
      prev = model;
      if (fl) begin
         model.valid   = 1'b0;
         model.rwe     = 1'b0;
         model.mis     = 1'b0;
         model.data    = '0;
         model.addr    = '0;
         model.bypEn   = 1'b0;
         model.bypAddr = '0;
         model.bypData = '0;
      end else if (!st) begin
         mis           = refMis(lt, off);
         model.bypEn   = prev.rwe;
         model.bypAddr = prev.addr;
         model.bypData = prev.data;
         model.valid   = v;
         model.addr    = ra;
         model.data    = refData(word, lt, off);
         model.mis     = mis;
         model.rwe     = v && rwe && (ra != 0) && !mis;
         if (v && !mis) model.cnt = prev.cnt + 1;
      end
      expQ.push_back(model);
   endtask

   task automatic resetPulse();
      @(negedge clk);
      stall     = 1'b1;
      flush     = 1'b0;
      mem_valid = 1'b0;
      #2 rst = 1'b1;
      #1 checkAllZero("mid-cycle reset");
      #1 rst = 1'b0;
      model = '{default: '0};
   endtask

   // Monitor: outputs are registered, so every rising edge presents a new WB entry.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst && expQ.size() > 0) checkOutput(expQ.pop_front());
      end
   end

   initial begin
      model = '{default: '0};
      repeat (2) @(posedge clk);
      #2 checkAllZero("reset held");
      @(negedge clk);
      stall = 1'b1;
      rst   = 1'b0;

      applyStimulus(1'b1, 32'h12F45678, 5'd8, 1'b1, 1, 1, 1'b0, 1'b0);
      @(posedge clk); #2;
      cmp("lb_data", write_data, 32'hFFFFFFF4);
      cmp("lb_rwe", 32'(reg_write_en), 32'd1);
      cmp("lb_addr", 32'(write_reg_addr), 32'd8);

      applyStimulus(1'b1, 32'h1234ABCD, 5'd9, 1'b1, 4, 2, 1'b0, 1'b0);
      @(posedge clk); #2;
      cmp("lhu_data", write_data, 32'h0000ABCD);

      applyStimulus(1'b1, 32'h1234ABCD, 5'd10, 1'b1, 5, 2, 1'b0, 1'b0);
      @(posedge clk); #2;
      cmp("lw_misalign", 32'(load_misalign), 32'd1);
      cmp("lw_rwe", 32'(reg_write_en), 32'd0);
      cmp("lw_count", retire_count, 32'd2);

      applyStimulus(1'b1, 32'hDEADBEEF, 5'd3, 1'b1, 0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, $urandom, 5'($urandom_range(1, 31)), 1'b1, 0, 0, 1'b1, 1'b0);
         @(posedge clk); #2;
         cmp("stall_data", write_data, 32'hDEADBEEF);
         cmp("stall_addr", 32'(write_reg_addr), 32'd3);
         cmp("stall_count", retire_count, 32'd3);
      end

      applyStimulus(1'b1, 32'h0BADF00D, 5'd5, 1'b1, 0, 0, 1'b1, 1'b1);
      @(posedge clk); #2;
      cmp("sf_valid", 32'(wb_valid), 32'd0);
      cmp("sf_rwe", 32'(reg_write_en), 32'd0);
      cmp("sf_data", write_data, 32'd0);

      applyStimulus(1'b1, 32'h5, 5'd0, 1'b1, 0, 0, 1'b0, 1'b0);
      @(posedge clk); #2;
      cmp("r0_rwe", 32'(reg_write_en), 32'd0);
      cmp("r0_valid", 32'(wb_valid), 32'd1);
      cmp("r0_count", retire_count, 32'd4);

      @(negedge clk);
      stall = 1'b1;
      flush = 1'b0;
      force dut.retireCount_q = 32'hFFFFFFFF;
      #1 release dut.retireCount_q;
      model.cnt = 32'hFFFFFFFF;
      applyStimulus(1'b1, 32'hCAFE0001, 5'd7, 1'b1, 0, 0, 1'b0, 1'b0);
      @(posedge clk); #2;
      cmp("wrap_count", retire_count, 32'd0);

      resetPulse();

      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom), $urandom, 5'($urandom), 1'($urandom),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      end

      @(posedge clk); #2;
      cmp("scoreboard_drained", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
